// File: rtl/scene_pkg.sv
// Shared definitions for the pokemon choose scene: controller state encoding and grid geometry.
// The scene renderer uses the same tile constants.
package scene_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BROWSE,
    CONFIRM_WAIT,
    HOLD
  } scene_state_t;

  localparam int unsigned GRID_COLS  = 4;
  localparam int unsigned GRID_ROWS  = 2;
  localparam int unsigned TILE_H0    = 40;
  localparam int unsigned TILE_V0    = 80;
  localparam int unsigned TILE_PITCH = 160;
  localparam int unsigned TILE_LEN   = 120;

endpackage

// File: rtl/frame_blink_timer.sv
// Counts frame ticks modulo (last+1) and strobes on the tick that reaches the terminal count.
// A clear restarts the count from zero and suppresses the strobe on that cycle.
module frame_blink_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] last,
  output logic       strobe
);

  logic [7:0] count;

  assign strobe = tick & ~clear & (count == last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= (count == last) ? '0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/poke_select_ctrl.sv
// Button-driven cursor over the 2x4 pokemon grid with confirm/cancel, producing the confirmed
// pokemon_id, the cursor-frame position and a blink strobe for the frame overlay.
module poke_select_ctrl
  import scene_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES   = 15,
  parameter int unsigned CONFIRM_FRAMES = 30,
  parameter int unsigned ID_W           = 8,
  parameter int unsigned CNT_W          = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_confirm,
  input  logic             btn_cancel,
  output logic [ID_W-1:0]  cursor_id,
  output logic [ID_W-1:0]  pokemon_id,
  output logic [CNT_W-1:0] frame_h_start,
  output logic [CNT_W-1:0] frame_v_start,
  output logic             blink_on,
  output logic             choose_done,
  output logic             busy
);

  scene_state_t state;
  logic [1:0]   col;
  logic         row;

  logic       act_confirm;
  logic       mv_left;
  logic       mv_right;
  logic       mv_vert;
  logic       any_move;
  logic       timer_clear;
  logic       timer_strobe;
  logic [7:0] timer_last;

  // One action per cycle: cancel > confirm > left > right > up/down (up and down both toggle row).
  always_comb begin
    act_confirm = btn_confirm & ~btn_cancel;
    mv_left     = btn_left & ~btn_cancel & ~btn_confirm;
    mv_right    = btn_right & ~btn_cancel & ~btn_confirm & ~btn_left;
    mv_vert     = (btn_up | btn_down) & ~btn_cancel & ~btn_confirm & ~btn_left & ~btn_right;
    any_move    = mv_left | mv_right | mv_vert;
    timer_last  = (state == CONFIRM_WAIT) ? 8'(CONFIRM_FRAMES - 1) : 8'(BLINK_FRAMES - 1);
    timer_clear = ~enable;
    case (state)
      BROWSE:       if (act_confirm || any_move) timer_clear = 1'b1;
      CONFIRM_WAIT: if (btn_cancel) timer_clear = 1'b1;
      default:      timer_clear = 1'b1;
    endcase
  end

  frame_blink_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .tick   (frame_tick),
    .last   (timer_last),
    .strobe (timer_strobe)
  );

  assign cursor_id     = ID_W'({row, col}) + ID_W'(1);
  assign frame_h_start = CNT_W'(TILE_H0) + CNT_W'(TILE_PITCH) * CNT_W'(col);
  assign frame_v_start = CNT_W'(TILE_V0) + CNT_W'(TILE_PITCH) * CNT_W'(row);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      pokemon_id  <= '0;
      blink_on    <= 1'b0;
      choose_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      choose_done <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        blink_on <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= BROWSE;
            blink_on   <= 1'b1;
            pokemon_id <= '0;
          end
          BROWSE: begin
            if (act_confirm) begin
              pokemon_id <= cursor_id;
              state      <= CONFIRM_WAIT;
              busy       <= 1'b1;
            end else if (any_move) begin
              blink_on <= 1'b1;
              if (mv_left)  col <= (col == '0) ? 2'(GRID_COLS - 1) : col - 2'd1;
              if (mv_right) col <= (col == 2'(GRID_COLS - 1)) ? '0 : col + 2'd1;
              if (mv_vert)  row <= (row == 1'(GRID_ROWS - 1)) ? '0 : row + 1'b1;
            end else if (timer_strobe) begin
              blink_on <= ~blink_on;
            end
          end
          CONFIRM_WAIT: begin
            if (btn_cancel) begin
              pokemon_id <= '0;
              state      <= BROWSE;
              blink_on   <= 1'b1;
              busy       <= 1'b0;
            end else if (timer_strobe) begin
              choose_done <= 1'b1;
              blink_on    <= 1'b1;
              state       <= HOLD;
              busy        <= 1'b0;
            end else if (frame_tick) begin
              blink_on <= ~blink_on;
            end
          end
          HOLD: begin
            if (btn_cancel) begin
              pokemon_id <= '0;
              state      <= BROWSE;
              blink_on   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
